// File: rtl/wallace_mul_seq.sv
// Iterative 32x32 RV32M multiplier: one combinational 8x8 Wallace-tree product
// stepped over 16 byte pairs, accumulated into a 64-bit register, sign-fixed at the end.

module wallace_8x8_product (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [7:0][15:0] pp;
   logic [1:0][15:0] l1a, l1b, l2a, l2b, l3, l4;

   // 3:2 compressor on whole rows: [0] = sum, [1] = carry already weighted by 2
   function automatic logic [1:0][15:0] csa(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
      logic [15:0] maj;
      maj = (x & y) | (x & z) | (y & z);
      return {{maj[14:0], 1'b0}, x ^ y ^ z};
   endfunction

   for (genvar r = 0; r < 8; r++) begin : g_pp
      assign pp[r] = b[r] ? (16'(a) << r) : 16'd0;
   end

   // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
   assign l1a = csa(pp[0], pp[1], pp[2]);
   assign l1b = csa(pp[3], pp[4], pp[5]);
   assign l2a = csa(l1a[0], l1a[1], l1b[0]);
   assign l2b = csa(l1b[1], pp[6], pp[7]);
   assign l3  = csa(l2a[0], l2a[1], l2b[0]);
   assign l4  = csa(l3[0], l3[1], l2b[1]);
   assign p   = l4[0] + l4[1];
endmodule

module wallace_mul_seq #(
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] res_o
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, nxt;
   logic [31:0] ma, mb, abs_a, abs_b;
   logic [1:0]  op;
   logic        neg, a_neg, b_neg, go, skip;
   logic [63:0] acc, term, r64;
   logic [3:0]  k;
   logic [5:0]  sh;
   logic [7:0]  a_byte, b_byte;
   logic [15:0] p16;

   assign go    = start_i && !kill_i;
   assign a_neg = (op_i == 2'b01 || op_i == 2'b10) && a_i[31];
   assign b_neg = (op_i == 2'b01) && b_i[31];
   assign abs_a = a_neg ? (~a_i + 32'd1) : a_i;
   assign abs_b = b_neg ? (~b_i + 32'd1) : b_i;
   assign skip  = ZERO_SKIP && (a_i == 32'd0 || b_i == 32'd0);

   assign a_byte = ma[8*k[1:0] +: 8];
   assign b_byte = mb[8*k[3:2] +: 8];
   assign sh     = {({1'b0, k[1:0]} + {1'b0, k[3:2]}), 3'b000};
   assign term   = {48'd0, p16} << sh;
   assign r64    = neg ? (~acc + 64'd1) : acc;

   wallace_8x8_product u_prod (.a(a_byte), .b(b_byte), .p(p16));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (go) nxt = skip ? FIX : CALC;
         CALC:    if (kill_i) nxt = IDLE;
                  else if (k == 4'd15) nxt = FIX;
         FIX:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state == CALC) || (state == FIX);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ma     <= '0;
         mb     <= '0;
         op     <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         k      <= '0;
         res_o  <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (go) begin
               ma  <= abs_a;
               mb  <= abs_b;
               op  <= op_i;
               neg <= a_neg ^ b_neg;
               acc <= '0;
               k   <= '0;
            end
            CALC: if (!kill_i) begin
               acc <= acc + term;
               k   <= k + 4'd1;
            end
            FIX: if (!kill_i) begin
               res_o  <= (op == 2'b00) ? r64[31:0] : r64[63:32];
               done_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_wallace_mul_seq.sv
// Directed bench for wallace_mul_seq: timing, all four ops, corner operands,
// kill, reset, busy-start, back-to-back and zero skip (both settings).

module tb_wallace_mul_seq;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, busy_nz, done_nz;
   logic [31:0] res, res_nz;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   wallace_mul_seq #(.ZERO_SKIP(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .kill_i(kill), .op_i(op),
      .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .res_o(res));

   wallace_mul_seq #(.ZERO_SKIP(1'b0)) dut_nz (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .kill_i(kill), .op_i(op),
      .a_i(a), .b_i(b), .busy_o(busy_nz), .done_o(done_nz), .res_o(res_nz));

   // Launch an op (sampled at edge E0), scramble operands afterwards, then
   // return the number of edges after E0 at which done was seen (0 = timeout).
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int n);
      @(negedge clk); start = 1'b1; op = o; a = x; b = y;
      @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
      n = 0;
      r = res;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin n = i; r = res; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, res, busy_nz, done_nz, res_nz} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b res=%h (nz %b %b %h), want all 0",
                  busy, done, res, busy_nz, done_nz, res_nz);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
      @(negedge clk); start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0: got %b want 1", busy); end
      for (int n = 1; n <= 17; n++) begin
         @(negedge clk);
         checks++;
         if (busy !== (n < 17) || done !== (n == 17)) begin
            errors++;
            $display("FAIL basic_timing E%0d: got busy=%b done=%b want busy=%b done=%b",
                     n, busy, done, n < 17, n == 17);
         end
      end
      checks++;
      if (res !== 32'h0000_000F) begin errors++; $display("FAIL basic_res: got %h want 0000000f", res); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: done still %b", done); end
   endtask

   task automatic test_all_ops();
      logic [31:0] exp [4];
      logic [31:0] r;
      int          n;
      exp[0] = 32'h0000_0001; exp[1] = 32'h0000_0000;
      exp[2] = 32'hFFFF_FFFF; exp[3] = 32'hFFFF_FFFE;
      for (int o = 0; o < 4; o++) begin
         do_op(2'(o), 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, n);
         checks++;
         if (n != 17 || r !== exp[o]) begin
            errors++;
            $display("FAIL all_ops op=%0d: got res=%h at E%0d want %h at E17", o, r, n, exp[o]);
         end
      end
   endtask

   task automatic test_corners();
      logic [1:0]  ops [5];
      logic [31:0] as [5], bs [5], exp [5];
      logic [31:0] r;
      int          n;
      ops[0] = 2'b01; as[0] = 32'h8000_0000; bs[0] = 32'h8000_0000; exp[0] = 32'h4000_0000;
      ops[1] = 2'b00; as[1] = 32'h1234_5678; bs[1] = 32'h9ABC_DEF0; exp[1] = 32'h242D_2080;
      ops[2] = 2'b10; as[2] = 32'h8000_0000; bs[2] = 32'h8000_0000; exp[2] = 32'hC000_0000;
      ops[3] = 2'b01; as[3] = 32'hFFFF_FFFE; bs[3] = 32'd3;         exp[3] = 32'hFFFF_FFFF;
      ops[4] = 2'b00; as[4] = 32'hFFFF_FFFE; bs[4] = 32'd3;         exp[4] = 32'hFFFF_FFFA;
      for (int t = 0; t < 5; t++) begin
         do_op(ops[t], as[t], bs[t], r, n);
         checks++;
         if (n != 17 || r !== exp[t]) begin
            errors++;
            $display("FAIL corner_%0d: got res=%h at E%0d want %h at E17", t, r, n, exp[t]);
         end
      end
   endtask

   task automatic test_kill();
      int n;
      @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
      @(negedge clk); start = 1'b0;
      for (int i = 1; i <= 7; i++) @(negedge clk);
      kill = 1'b1;
      @(negedge clk); kill = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || res !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL kill_abort: got busy=%b done=%b res=%h want 0 0 fffffffa", busy, done, res);
      end
      start = 1'b1; a = 32'd7; b = 32'd9;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin n = i; break; end
      end
      checks++;
      if (n != 17 || res !== 32'h0000_003F) begin
         errors++;
         $display("FAIL kill_restart: got res=%h at E%0d after restart want 0000003f at E17", res, n);
      end
      // start together with kill in IDLE must be dropped
      @(negedge clk); start = 1'b1; kill = 1'b1; a = 32'd2; b = 32'd2;
      @(negedge clk); start = 1'b0; kill = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL kill_start_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_busy_ignore();
      int n, extra;
      @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 5) begin start = 1'b1; op = 2'b11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
         if (i == 6) start = 1'b0;
         if (done) begin n = i; break; end
      end
      checks++;
      if (n != 17 || res !== 32'h0000_000F) begin
         errors++;
         $display("FAIL busy_ignore_res: got res=%h at E%0d want 0000000f at E17", res, n);
      end
      extra = 0;
      for (int i = 0; i < 25; i++) begin @(negedge clk); if (done || busy) extra++; end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL busy_ignore_queued: got %0d active cycles want 0", extra); end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin n = i; break; end
      end
      checks++;
      if (n != 17 || res !== 32'h0000_003F) begin
         errors++;
         $display("FAIL b2b_first: got res=%h at E%0d want 0000003f at E17", res, n);
      end
      start = 1'b1; op = 2'b11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin n = i; break; end
      end
      checks++;
      if (n != 17 || res !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL b2b_second: got res=%h at E%0d want fffffffe at E17", res, n);
      end
   endtask

   task automatic test_zero_skip();
      int          dz, dnz;
      logic [31:0] rz, rnz;
      dz = 0; dnz = 0; rz = 32'hDEAD_BEEF; rnz = 32'hDEAD_BEEF;
      @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd0; b = 32'h1234_5678;
      @(negedge clk); start = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (done && dz == 0) begin dz = i; rz = res; end
         if (done_nz && dnz == 0) begin dnz = i; rnz = res_nz; end
      end
      checks++;
      if (dz != 1 || rz !== 32'd0) begin
         errors++;
         $display("FAIL zero_skip_on: got res=%h at E%0d want 00000000 at E1", rz, dz);
      end
      checks++;
      if (dnz != 17 || rnz !== 32'd0) begin
         errors++;
         $display("FAIL zero_skip_off: got res=%h at E%0d want 00000000 at E17", rnz, dnz);
      end
   endtask

   task automatic test_mid_reset();
      int extra;
      @(negedge clk); start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      @(negedge clk); start = 1'b0;
      for (int i = 1; i <= 4; i++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b done=%b res=%h want 0 0 00000000", busy, done, res);
      end
      extra = 0;
      for (int i = 0; i < 25; i++) begin @(negedge clk); if (done || busy) extra++; end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL mid_reset_dropped: got %0d active cycles want 0", extra); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_ops();
      test_corners();
      test_kill();
      test_busy_ignore();
      test_back_to_back();
      test_zero_skip();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end
endmodule
